// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, drives a combinational ROM port and
// buffers fetched words in a 2-entry FIFO presented to decode via valid/ready.
module inst_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  rom_ce_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_inst_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  id_valid_o,
    input  logic                  id_ready_i,
    output logic [DATA_WIDTH-1:0] id_inst_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic                  misalign_o
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  misalign_q, misalign_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q [2];
    logic [ADDR_WIDTH-1:0] pc_mem_d [2];
    logic [DATA_WIDTH-1:0] inst_mem_q [2];
    logic [DATA_WIDTH-1:0] inst_mem_d [2];

    logic enq_ok;
    logic fetch;
    logic pop;
    logic redirect_take;

    // A full FIFO can still accept a push when decode drains the head this cycle.
    assign enq_ok        = (count_q < 2'd2) || ((count_q == 2'd2) && id_ready_i);
    assign redirect_take = redirect_i && (state_q != BOOT);
    assign fetch         = (state_q == RUN) && enq_ok && !redirect_i;
    assign pop           = (count_q != 2'd0) && id_ready_i;

    assign rom_ce_o   = fetch;
    assign rom_addr_o = fetch ? pc_q : '0;
    assign id_valid_o = (count_q != 2'd0);
    assign id_inst_o  = id_valid_o ? inst_mem_q[rd_ptr_q] : '0;
    assign id_pc_o    = id_valid_o ? pc_mem_q[rd_ptr_q] : '0;
    assign misalign_o = misalign_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        misalign_d = 1'b0;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!redirect_i && !enq_ok) state_d = STALL;
            STALL:   if (redirect_i || enq_ok) state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (redirect_take) begin
            // Flush discards everything, including an entry decode pops this cycle.
            pc_d       = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            misalign_d = |redirect_pc_i[1:0];
        end else begin
            if (fetch) begin
                pc_mem_d[wr_ptr_q]   = pc_q;
                inst_mem_d[wr_ptr_q] = rom_inst_i;
                wr_ptr_d             = ~wr_ptr_q;
                pc_d                 = pc_q + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(fetch) - 2'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            misalign_q <= 1'b0;
            pc_mem_q   <= '{default: '0};
            inst_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            misalign_q <= misalign_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot sequence, backpressure, redirects,
// misalignment, PC wrap and asynchronous reset mid-stream.
module tb_inst_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        misalign_o;

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    // ROM contents: each word is its address XOR a fixed pattern.
    assign rom_inst_i = rom_addr_o ^ 32'hDEAD_BEEF;

    inst_fetch dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rom_ce_o     (rom_ce_o),
        .rom_addr_o   (rom_addr_o),
        .rom_inst_i   (rom_inst_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_inst_o    (id_inst_o),
        .id_pc_o      (id_pc_o),
        .misalign_o   (misalign_o)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] addr);
        check({tag, " ce"}, {31'd0, rom_ce_o}, 32'd1);
        check({tag, " addr"}, rom_addr_o, addr);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, {31'd0, id_valid_o}, 32'd1);
        check({tag, " pc"}, id_pc_o, pc);
        check({tag, " inst"}, id_inst_o, inst_of(pc));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ce"}, {31'd0, rom_ce_o}, 32'd0);
        check({tag, " addr"}, rom_addr_o, 32'd0);
        check({tag, " valid"}, {31'd0, id_valid_o}, 32'd0);
        check({tag, " inst"}, id_inst_o, 32'd0);
        check({tag, " pc"}, id_pc_o, 32'd0);
        check({tag, " misalign"}, {31'd0, misalign_o}, 32'd0);
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i         = 1'b1;
        id_ready_i    = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        // Cycle 0: BOOT
        check("boot ce", {31'd0, rom_ce_o}, 32'd0);
        $display("boot: ce=%0b valid=%0b", rom_ce_o, id_valid_o);
        next_cycle(); check_fetch("c1", 32'h8000_0000);
        $display("c1: fetch %08h", rom_addr_o);
        next_cycle(); check_fetch("c2", 32'h8000_0004); check_head("c2", 32'h8000_0000);
        $display("c2: fetch %08h head %08h", rom_addr_o, id_pc_o);
        next_cycle(); check_fetch("c3", 32'h8000_0008); check_head("c3", 32'h8000_0004);
        $display("c3: fetch %08h head %08h", rom_addr_o, id_pc_o);
        next_cycle(); check_fetch("c4", 32'h8000_000C); check_head("c4", 32'h8000_0008);
        $display("c4: fetch %08h head %08h", rom_addr_o, id_pc_o);
        next_cycle(); check_head("c5", 32'h8000_000C);
        $display("c5: head %08h", id_pc_o);

        // Backpressure from reset
        rst_i      = 1'b1;
        id_ready_i = 1'b0;
        next_cycle();
        rst_i = 1'b0;
        #1;
        check("bp boot ce", {31'd0, rom_ce_o}, 32'd0);
        next_cycle(); check_fetch("bp c1", 32'h8000_0000);
        next_cycle(); check_fetch("bp c2", 32'h8000_0004); check_head("bp c2", 32'h8000_0000);
        next_cycle(); check("bp c3 full ce", {31'd0, rom_ce_o}, 32'd0);
        $display("bp c3: full, ce=%0b", rom_ce_o);
        next_cycle(); check("bp stall ce", {31'd0, rom_ce_o}, 32'd0);
        check_head("bp stall", 32'h8000_0000);
        id_ready_i = 1'b1;
        #1;
        check("bp release ce", {31'd0, rom_ce_o}, 32'd0);
        $display("bp release: dequeue %08h", id_pc_o);
        next_cycle(); check_fetch("bp c5", 32'h8000_0008); check_head("bp c5", 32'h8000_0004);
        $display("bp c5: fetch %08h head %08h", rom_addr_o, id_pc_o);
        next_cycle(); check_fetch("bp c6", 32'h8000_000C); check_head("bp c6", 32'h8000_0008);
        id_ready_i = 1'b0;
        next_cycle(); check("bp c7 full ce", {31'd0, rom_ce_o}, 32'd0);
        check_head("bp c7", 32'h8000_0008);

        // Redirect with a full FIFO
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        #1;
        check("redir ce", {31'd0, rom_ce_o}, 32'd0);
        next_cycle();
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        #1;
        check("redir flush valid", {31'd0, id_valid_o}, 32'd0);
        check_fetch("redir c1", 32'h8000_0100);
        check("redir misalign", {31'd0, misalign_o}, 32'd0);
        $display("redirect: fetch %08h valid=%0b", rom_addr_o, id_valid_o);
        next_cycle(); check_head("redir c2", 32'h8000_0100); check_fetch("redir c2", 32'h8000_0104);

        // Misaligned redirect
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0106;
        #1;
        check("mis c0 flag", {31'd0, misalign_o}, 32'd0);
        check("mis c0 ce", {31'd0, rom_ce_o}, 32'd0);
        next_cycle();
        redirect_i = 1'b0;
        #1;
        check("mis c1 flag", {31'd0, misalign_o}, 32'd1);
        check_fetch("mis c1", 32'h8000_0104);
        $display("misalign: flag=%0b fetch %08h", misalign_o, rom_addr_o);
        next_cycle();
        check("mis c2 flag", {31'd0, misalign_o}, 32'd0);
        check_head("mis c2", 32'h8000_0104);
        check_fetch("mis c2", 32'h8000_0108);

        // Wrap past the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        next_cycle();
        redirect_i = 1'b0;
        #1;
        check_fetch("wrap c1", 32'hFFFF_FFFC);
        check("wrap c1 misalign", {31'd0, misalign_o}, 32'd0);
        next_cycle(); check_fetch("wrap c2", 32'h0000_0000); check_head("wrap c2", 32'hFFFF_FFFC);
        $display("wrap: fetch %08h head %08h", rom_addr_o, id_pc_o);
        next_cycle(); check_fetch("wrap c3", 32'h0000_0004); check_head("wrap c3", 32'h0000_0000);

        // Asynchronous reset mid-cycle with one entry buffered
        #2 rst_i = 1'b1;
        #1;
        check_reset_outputs("async");
        $display("async reset: ce=%0b valid=%0b pc=%08h", rom_ce_o, id_valid_o, id_pc_o);
        next_cycle();
        rst_i = 1'b0;
        // Redirect during BOOT is ignored
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0200;
        #1;
        check("rst boot ce", {31'd0, rom_ce_o}, 32'd0);
        next_cycle();
        redirect_i = 1'b0;
        #1;
        check_fetch("rst c1", 32'h8000_0000);
        check("rst c1 misalign", {31'd0, misalign_o}, 32'd0);
        next_cycle(); check_fetch("rst c2", 32'h8000_0004); check_head("rst c2", 32'h8000_0000);
        $display("restart: fetch %08h head %08h", rom_addr_o, id_pc_o);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
